// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART link and writes it into
//   instruction memory. The image is a 4-byte little-endian word count N
//   followed by N little-endian 32-bit words, written to word addresses
//   0..N-1. While busy is high the core is expected to be held in reset.
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   rx_i        : asynchronous UART input, idle high, LSB first
//   start       : one-cycle pulse arming a load (ignored while loading)
//   busy        : load in progress (HDR or DATA)
//   done / err  : sticky completion / failure flags, cleared by start
//   we, waddr,  : one-cycle instruction-memory write strobe, word address
//   wdata       :   and data (address/data meaningful only with we)
//   word_count  : words written so far in the current load
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14,
    parameter int MAX_WORDS    = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      MAX_W32 = 32'(MAX_WORDS);

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_s1, rx_s2;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic             rx_tick, byte_valid, frame_err;

    always_comb begin
        rx_next    = rx_state;
        rx_tick    = 1'b0;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_s2) rx_next = RX_START;
            // Mid-start-bit check rejects glitches shorter than half a bit.
            RX_START: if (clk_cnt == HALF_M1) begin
                rx_tick = 1'b1;
                rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (clk_cnt == FULL_M1) begin
                rx_tick = 1'b1;
                if (bit_cnt == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP:  if (clk_cnt == FULL_M1) begin
                rx_tick    = 1'b1;
                rx_next    = RX_IDLE;
                byte_valid = rx_s2;
                frame_err  = !rx_s2;
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rx_i;
            rx_s2    <= rx_s1;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || rx_tick) clk_cnt <= '0;
            else                                clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                bit_cnt  <= bit_cnt + 3'd1;
            end else if (rx_state == RX_START) begin
                bit_cnt  <= '0;
            end
        end
    end

    // ---------------- loader ----------------
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} ld_state_t;

    ld_state_t             state, state_next;
    logic [1:0]            byte_idx;
    logic [23:0]           asm_q;      // first three bytes of the current word
    logic [ADDR_WIDTH:0]   n_words;
    logic [31:0]           full_word;
    logic                  restart, take, last_byte;

    assign full_word = {rx_shift, asm_q};
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);
    assign take      = byte_valid && (state == HDR || state == DATA);
    assign last_byte = take && (byte_idx == 2'd3);

    assign busy = (state == HDR) || (state == DATA);
    assign done = (state == DONE);
    assign err  = (state == ERR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = HDR;
            HDR: begin
                if (frame_err)                state_next = ERR;
                else if (last_byte) begin
                    if (full_word == 32'd0)   state_next = DONE;
                    else if (full_word > MAX_W32) state_next = ERR;
                    else                      state_next = DATA;
                end
            end
            // word_count is already incremented in the we cycle.
            DATA: begin
                if (frame_err)                          state_next = ERR;
                else if (we && word_count == n_words)   state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            asm_q      <= '0;
            n_words    <= '0;
            word_count <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            state <= state_next;
            we    <= 1'b0;
            if (restart) begin
                byte_idx   <= '0;
                word_count <= '0;
            end else if (take) begin
                byte_idx <= byte_idx + 2'd1;
                asm_q    <= {rx_shift, asm_q[23:8]};
                if (byte_idx == 2'd3) begin
                    if (state == HDR) begin
                        n_words <= full_word[ADDR_WIDTH:0];
                    end else begin
                        we         <= 1'b1;
                        waddr      <= word_count[ADDR_WIDTH-1:0];
                        wdata      <= full_word;
                        word_count <= word_count + (ADDR_WIDTH+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int MW  = 16;

    logic          clk = 1'b0;
    logic          rst, rx_i, start;
    logic          busy, done, err, we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .start(start),
        .busy(busy), .done(done), .err(err), .we(we),
        .waddr(waddr), .wdata(wdata), .word_count(word_count)
    );

    int nvec = 0;
    int nmis = 0;

    logic [7:0]    stream[$];
    bit            ok[$];
    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];
    logic          got_dn[$];
    logic [31:0]   ewd[$];
    bit            e_done, e_err;
    int            e_wc;

    // write monitor
    always @(negedge clk) begin
        if (we) begin
            got_a.push_back(waddr);
            got_d.push_back(wdata);
            got_dn.push_back(done);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        @(negedge clk);
        rx_i = v;
        repeat (CPB-1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_ok);
        if (!stop_ok) bit_out(1'b1);
        for (int i = 0; i < gap; i++) bit_out(1'b1);
    endtask

    task automatic pulse_start(input string nm);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, ".busy_rise"}, int'(busy), 1);
    endtask

    task automatic clear_got();
        got_a.delete(); got_d.delete(); got_dn.delete();
    endtask

    task automatic build(input int unsigned n, input int nd);
        stream.delete();
        for (int k = 0; k < 4; k++) stream.push_back(8'((n >> (8*k)) & 32'hff));
        for (int i = 0; i < nd; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_stream(input int bad, input int gap);
        ok.delete();
        for (int i = 0; i < stream.size(); i++) ok.push_back(i != bad);
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], ok[i], gap);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    // Reference: walk the byte list as a header plus whole words, stopping
    // at the first bad-stop byte.
    task automatic model();
        int fb;
        int unsigned nh;
        fb = stream.size();
        for (int i = 0; i < ok.size(); i++) if (!ok[i]) begin fb = i; break; end
        ewd.delete(); e_done = 0; e_err = 0; e_wc = 0;
        if (fb < 4) begin e_err = 1; return; end
        nh = {stream[3], stream[2], stream[1], stream[0]};
        if (nh == 0) e_done = 1;
        else if (nh > MW) e_err = 1;
        else begin
            for (int w = 0; w < int'(nh); w++) begin
                int base = 4 + 4*w;
                if (base + 3 < fb && base + 3 < stream.size())
                    ewd.push_back({stream[base+3], stream[base+2], stream[base+1], stream[base]});
                else break;
            end
            e_wc = ewd.size();
            if (e_wc == int'(nh)) e_done = 1;
            else if (fb < stream.size()) e_err = 1;
        end
    endtask

    task automatic check_flags(input string nm, input bit d, input bit e, input int wc);
        chk({nm, ".done"}, int'(done), int'(d));
        chk({nm, ".err"}, int'(err), int'(e));
        chk({nm, ".word_count"}, int'(word_count), wc);
        chk({nm, ".busy"}, int'(busy), int'(!(d || e)));
    endtask

    task automatic check_writes(input string nm);
        int n;
        chk({nm, ".n_we"}, got_a.size(), ewd.size());
        n = (got_a.size() < ewd.size()) ? got_a.size() : ewd.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.waddr[%0d]", nm, i), int'(got_a[i]), i);
            chk($sformatf("%s.wdata[%0d]", nm, i), int'(got_d[i]), int'(ewd[i]));
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".busy"}, int'(busy), 0);
        chk({nm, ".done"}, int'(done), 0);
        chk({nm, ".err"}, int'(err), 0);
        chk({nm, ".we"}, int'(we), 0);
        chk({nm, ".waddr"}, int'(waddr), 0);
        chk({nm, ".wdata"}, int'(wdata), 0);
        chk({nm, ".word_count"}, int'(word_count), 0);
    endtask

    typedef struct {
        int unsigned n;
        int          nd;
        int          bad;
        int          gap;
        bit          e_done;
        bit          e_err;
        int          e_wc;
    } vec_t;

    initial begin
        vec_t tbl[8];
        tbl[0] = '{0,   0,  -1, 0, 1'b1, 1'b0, 0};   // empty image
        tbl[1] = '{17,  0,  -1, 0, 1'b0, 1'b1, 0};   // oversize by one
        tbl[2] = '{3,   12, 8,  1, 1'b0, 1'b1, 1};   // bad stop after one word
        tbl[3] = '{16,  64, -1, 0, 1'b1, 1'b0, 16};  // full image
        tbl[4] = '{1,   4,  -1, 1, 1'b1, 1'b0, 1};
        tbl[5] = '{2,   0,  2,  0, 1'b0, 1'b1, 0};   // bad stop inside header
        tbl[6] = '{256, 0,  -1, 0, 1'b0, 1'b1, 0};   // oversize via byte 1
        tbl[7] = '{2,   12, -1, 0, 1'b1, 1'b0, 2};   // trailing bytes dropped

        rx_i = 1'b1; start = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        clear_got();
        repeat (200) @(negedge clk);
        chk("reset.no_we", got_a.size(), 0);

        // normal load, back-to-back frames
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};
        clear_got();
        pulse_start("normal");
        send_stream(-1, 0);
        ewd = '{32'h00100513, 32'h00200593};
        check_writes("normal");
        for (int i = 0; i < got_dn.size(); i++)
            chk($sformatf("normal.done_at_we[%0d]", i), int'(got_dn[i]), 0);
        check_flags("normal", 1'b1, 1'b0, 2);

        // table
        for (int t = 0; t < 8; t++) begin
            string nm = $sformatf("tbl%0d", t);
            build(tbl[t].n, tbl[t].nd);
            clear_got();
            pulse_start(nm);
            send_stream(tbl[t].bad, tbl[t].gap);
            model();
            check_flags(nm, tbl[t].e_done, tbl[t].e_err, tbl[t].e_wc);
            check_writes(nm);
        end

        // false start glitch, then a one-word load
        build(1, 4);
        clear_got();
        pulse_start("glitch");
        @(negedge clk); rx_i = 1'b0;
        @(negedge clk); rx_i = 1'b1;
        repeat (20) @(negedge clk);
        send_stream(-1, 0);
        model();
        check_flags("glitch", 1'b1, 1'b0, 1);
        check_writes("glitch");

        // reset mid-load after 6 data bytes
        build(2, 8);
        clear_got();
        pulse_start("midrst");
        for (int i = 0; i < 10; i++) send_byte(stream[i], 1'b1, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        chk("midrst.n_we", got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk("midrst.waddr0", int'(got_a[0]), 0);
            chk("midrst.wdata0", int'(got_d[0]), int'({stream[7], stream[6], stream[5], stream[4]}));
        end
        build(2, 8);
        clear_got();
        pulse_start("after_rst");
        send_stream(-1, 0);
        model();
        check_flags("after_rst", 1'b1, 1'b0, 2);
        check_writes("after_rst");

        // randomized loads against the reference model
        for (int r = 0; r < 8; r++) begin
            string nm = $sformatf("rnd%0d", r);
            int unsigned n = $urandom_range(0, 18);
            int nd = ((n <= MW) ? 4*int'(n) : 0) + 4*int'($urandom_range(0, 1));
            int bad = -1;
            build(n, nd);
            if ($urandom_range(0, 3) == 0) bad = int'($urandom_range(0, stream.size()-1));
            clear_got();
            pulse_start(nm);
            send_stream(bad, int'($urandom_range(0, 1)));
            model();
            check_flags(nm, e_done, e_err, e_wc);
            check_writes(nm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
